// File: rtl/bin_bcd_seq.sv
// rtl/bin_bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// One shared add-3 corrector is stepped across the BCD digits before each shift.
module bin_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int N_W   = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CORR  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_next;
  logic [K_W-1:0]   k;
  logic [N_W-1:0]   n;
  logic [3:0]       digit;
  logic [3:0]       corr;
  logic             cp;

  // Digit k is at most 9, so the 4-bit sum never exceeds 12 and needs no carry.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == K_W'(i)) digit = bcd_sh[4*i +: 4];
    end
    cp       = (digit >= 4'd5);
    corr     = digit + (cp ? 4'd3 : 4'd0);
    bcd_next = {bcd_sh[BCD_W-2:0], bin_sh[BIN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bin_sh  <= '0;
      bcd_sh  <= '0;
      k       <= '0;
      n       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            bin_sh <= bin_in;
            bcd_sh <= '0;
            k      <= '0;
            n      <= N_W'(BIN_W);
            busy   <= 1'b1;
            state  <= S_CORR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CORR: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (k == K_W'(i)) bcd_sh[4*i +: 4] <= corr;
          end
          if (k == K_W'(DIGITS - 1)) begin
            k     <= '0;
            state <= S_SHIFT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_SHIFT: begin
          bcd_sh <= bcd_next;
          bin_sh <= {bin_sh[BIN_W-2:0], 1'b0};
          n      <= n - 1'b1;
          // The final shift publishes the result; no correction follows it.
          if (n == N_W'(1)) begin
            bcd_out <= bcd_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_CORR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
